// File: rtl/s420_ctrl_pkg.sv
// s420_ctrl_pkg: shared state encoding and width defaults for the s420 sweep controller.
package s420_ctrl_pkg;
  localparam int CW_DEF = 16;
  localparam int MW_DEF = 17;
  localparam logic [31:0] ZERO_BUDGET_LAST = '1;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/s420_cyc_cnt.sv
// s420_cyc_cnt: RUN-cycle index counter with a last-cycle flag against the budget.
module s420_cyc_cnt
  import s420_ctrl_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] budget,
  output logic [CW-1:0] cnt,
  output logic          last
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  // A zero budget means a full 2^CW-cycle sweep.
  assign last = cnt == ((budget == '0) ? CW'(ZERO_BUDGET_LAST) : budget - 1'b1);
endmodule

// File: rtl/s420_sweep_ctrl.sv
// s420_sweep_ctrl: start/done sequencer that programs C_*, pulses P_0 for a bounded
// number of cycles and reports the first Z match of one s420 instance.
module s420_sweep_ctrl
  import s420_ctrl_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int MW = MW_DEF
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic [MW-1:0] MASK,
  input  logic [CW-1:0] MAX_CYC,
  input  logic          ACK,
  input  logic          Z_IN,
  output logic          P0_OUT,
  output logic [MW-1:0] C_OUT,
  output logic          BUSY,
  output logic          DONE,
  output logic          HIT,
  output logic [CW-1:0] HIT_CYC
);
  state_t state, nxt;
  logic [CW-1:0] budget, cyc;
  logic last;
  s420_cyc_cnt #(.CW(CW)) u_cnt (
    .clk(CK), .rst(RST), .clr(state != ST_RUN), .en(state == ST_RUN),
    .budget(budget), .cnt(cyc), .last(last)
  );
  // ABORT takes priority over a coincident hit or budget expiry.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  nxt = START ? ST_SETUP : ST_IDLE;
      ST_SETUP: nxt = ABORT ? ST_IDLE : ST_RUN;
      ST_RUN:   nxt = ABORT ? ST_IDLE : (Z_IN || last) ? ST_DONE : ST_RUN;
      ST_DONE:  nxt = ACK ? ST_IDLE : ST_DONE;
      default:  nxt = ST_IDLE;
    endcase
  end
  // Outputs are decoded from the next state so every output is a flop.
  always_ff @(posedge CK) begin
    if (RST) begin
      state   <= ST_IDLE;
      budget  <= '0;
      C_OUT   <= '0;
      P0_OUT  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      HIT     <= 1'b0;
      HIT_CYC <= '0;
    end else begin
      state   <= nxt;
      P0_OUT  <= nxt == ST_RUN;
      BUSY    <= nxt == ST_SETUP || nxt == ST_RUN;
      DONE    <= nxt == ST_DONE;
      HIT     <= nxt != ST_DONE ? 1'b0 : state == ST_RUN ? Z_IN : HIT;
      HIT_CYC <= nxt != ST_DONE ? '0 : state == ST_RUN ? (Z_IN ? cyc : '0) : HIT_CYC;
      if (state == ST_IDLE && START) begin
        C_OUT  <= MASK;
        budget <= MAX_CYC;
      end
    end
  end
endmodule

// File: tb/tb_s420_sweep_ctrl.sv
// tb_s420_sweep_ctrl: directed and randomized sweeps against a counter/AND-compare datapath stand-in.
module tb_s420_sweep_ctrl;
  localparam int CW = 16;
  localparam int MW = 17;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, ack = 1'b0, start4 = 1'b0, ack4 = 1'b0;
  logic [MW-1:0] mask = '0;
  logic [CW-1:0] max_cyc = '0;
  logic p0, busy, done, hit, p0_4, busy4, done4, hit4;
  logic [MW-1:0] c_out, c4;
  logic [CW-1:0] hit_cyc;
  logic [3:0] hit_cyc4;
  logic zsel = 1'b1, zforce = 1'b0, dp_clr = 1'b0, dp4_clr = 1'b0;
  logic [MW-1:0] dp = '0;
  int dp4 = 0;
  logic z;
  int n_chk = 0, n_fail = 0;
  s420_sweep_ctrl #(.CW(CW), .MW(MW)) dut (
    .CK(clk), .RST(rst), .START(start), .ABORT(abort), .MASK(mask), .MAX_CYC(max_cyc),
    .ACK(ack), .Z_IN(z), .P0_OUT(p0), .C_OUT(c_out), .BUSY(busy), .DONE(done),
    .HIT(hit), .HIT_CYC(hit_cyc)
  );
  s420_sweep_ctrl #(.CW(4), .MW(MW)) dut4 (
    .CK(clk), .RST(rst), .START(start4), .ABORT(1'b0), .MASK(mask), .MAX_CYC(4'd0),
    .ACK(ack4), .Z_IN(1'b0), .P0_OUT(p0_4), .C_OUT(c4), .BUSY(busy4), .DONE(done4),
    .HIT(hit4), .HIT_CYC(hit_cyc4)
  );
  always #5 clk = ~clk;
  // Datapath stand-in: counts P_0 pulses, Z is any overlap of the count with the compare word.
  assign z = zsel ? zforce : |(dp & c_out);
  always @(posedge clk) dp <= dp_clr ? '0 : dp + MW'(p0);
  always @(posedge clk) dp4 <= dp4_clr ? 0 : dp4 + int'(p0_4);
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_sweep(input logic [MW-1:0] m, input logic [CW-1:0] b);
    mask = m; max_cyc = b; start = 1'b1; dp_clr = 1'b1;
    step();
    start = 1'b0; dp_clr = 1'b0;
    chk("setup_busy", busy, 1);
    chk("setup_c_out", c_out, m);
    chk("setup_p0", p0, 0);
  endtask
  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!done && n < lim) begin
      step();
      n++;
    end
    chk("done_reached", done, 1);
  endtask
  task automatic acknowledge();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_done", done, 0);
    chk("ack_busy", busy, 0);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_p0"}, p0, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_hit_cyc"}, hit_cyc, 0);
  endtask
  // Reference: first RUN cycle whose pulse count overlaps the mask, or -1 on timeout.
  function automatic int exp_hit(input logic [MW-1:0] m, input int b);
    for (int k = 0; k < b; k++) if ((MW'(k) & m) != '0) return k;
    return -1;
  endfunction
  initial begin
    logic [MW-1:0] m;
    int b, k, n, d, sh;
    repeat (3) step();
    chk_idle("reset");
    chk("reset_c_out", c_out, 0);
    rst = 1'b0;
    repeat (5) begin
      step();
      chk("idle_p0", p0, 0);
    end
    chk_idle("idle");
    chk("idle_pulses", dp, 0);
    zsel = 1'b1; zforce = 1'b1;
    start_sweep(17'h00001, 16'd10);
    step();
    chk("imm_run_p0", p0, 1);
    chk("imm_run_done", done, 0);
    step();
    chk("imm_done", done, 1);
    chk("imm_hit", hit, 1);
    chk("imm_hit_cyc", hit_cyc, 0);
    chk("imm_p0", p0, 0);
    chk("imm_pulses", dp, 1);
    zforce = 1'b0;
    acknowledge();
    zsel = 1'b0;
    k = exp_hit(17'h00020, 100);
    start_sweep(17'h00020, 16'd100);
    step();
    mask = 17'h1ffff; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_c_out", c_out, 17'h00020);
    chk("busy_start_busy", busy, 1);
    wait_done(200, n);
    chk("mid_latency", 3 + n, k + 3);
    chk("mid_hit", hit, 1);
    chk("mid_hit_cyc", hit_cyc, k);
    chk("mid_pulses", dp, k + 1);
    repeat (7) begin
      step();
      chk("hold_done", done, 1);
      chk("hold_hit", hit, 1);
      chk("hold_hit_cyc", hit_cyc, k);
    end
    mask = 17'h00003; start = 1'b1; ack = 1'b1;
    step();
    start = 1'b0; ack = 1'b0;
    chk("sa_done", done, 0);
    chk("sa_busy", busy, 0);
    step();
    chk("sa_no_sweep", busy, 0);
    chk("sa_c_out", c_out, 17'h00020);
    zsel = 1'b1; zforce = 1'b0;
    start_sweep(17'h1ffff, 16'd4);
    wait_done(20, n);
    chk("to_latency", 1 + n, 6);
    chk("to_pulses", dp, 4);
    chk("to_hit", hit, 0);
    chk("to_hit_cyc", hit_cyc, 0);
    acknowledge();
    start4 = 1'b1; dp4_clr = 1'b1;
    step();
    start4 = 1'b0; dp4_clr = 1'b0;
    n = 0;
    while (!done4 && n < 40) begin
      step();
      n++;
    end
    chk("zb_done", done4, 1);
    chk("zb_pulses", dp4, 16);
    chk("zb_hit", hit4, 0);
    chk("zb_hit_cyc", hit_cyc4, 0);
    ack4 = 1'b1;
    step();
    ack4 = 1'b0;
    chk("zb_ack", done4, 0);
    start_sweep(17'h00001, 16'd50);
    repeat (3) step();
    zforce = 1'b1; abort = 1'b1;
    step();
    abort = 1'b0; zforce = 1'b0;
    chk_idle("abort");
    chk("abort_pulses", dp, 3);
    repeat (3) begin
      step();
      chk("abort_no_done", done, 0);
    end
    start_sweep(17'h00001, 16'd50);
    repeat (4) step();
    chk("rst_in_run", p0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("midrst");
    chk("midrst_c_out", c_out, 0);
    zsel = 1'b0;
    for (int i = 0; i < 24; i++) begin
      sh = $urandom_range(0, 8);
      m = MW'($urandom);
      m = m & ~((MW'(1) << sh) - MW'(1));
      b = $urandom_range(1, 300);
      k = exp_hit(m, b);
      start_sweep(m, CW'(b));
      wait_done(b + 10, n);
      if (k >= 0) begin
        chk("rnd_hit", hit, 1);
        chk("rnd_hit_cyc", hit_cyc, k);
        chk("rnd_pulses", dp, k + 1);
        chk("rnd_latency", 1 + n, k + 3);
      end else begin
        chk("rnd_miss", hit, 0);
        chk("rnd_miss_cyc", hit_cyc, 0);
        chk("rnd_miss_pulses", dp, b);
        chk("rnd_miss_latency", 1 + n, b + 2);
      end
      d = $urandom_range(0, 3);
      repeat (d) step();
      chk("rnd_done_held", done, 1);
      acknowledge();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/s420_sweep_ctrl.md
# s420_sweep_ctrl

Sequencer for the s420 counter/compare datapath: a start/done controller that programs the 17-bit compare word C_0..C_16 and drives the count-enable P_0 for a bounded number of cycles. It watches the datapath match output Z, reports whether and when a match occurred, and then hands the result to the requester. It sits between a host requester and one s420 instance. It is the only driver of that instance's P_0 and C_* inputs.

## Interface
Parameters:
- CW, 16: width of the cycle budget and hit-cycle counters.
- MW, 17: compare-word width; one bit per C_i, bit i drives C_i.

Ports:
- CK  in  1  clock, rising-edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  request a sweep; sampled only in IDLE.
- ABORT  in  1  cancel an in-progress sweep.
- MASK  in  MW  compare word, captured on accepted START.
- MAX_CYC  in  CW  RUN-cycle budget, captured on accepted START; 0 means 2^CW.
- ACK  in  1  requester has consumed the result.
- Z_IN  in  1  Z output of the s420 instance.
- P0_OUT  out  1  drives s420 P_0.
- C_OUT  out  MW  drives s420 C_0..C_16.
- BUSY  out  1  high in SETUP and RUN.
- DONE  out  1  high in DONE.
- HIT  out  1  a match was found; valid while DONE=1.
- HIT_CYC  out  CW  RUN-cycle index of the match; valid while DONE=1 and HIT=1.

## Operation
- States: IDLE, SETUP, RUN, DONE. Encoded in a 2-bit enum.
- IDLE:
  - P0_OUT=0.
  - START=1 captures MASK into C_OUT and MAX_CYC into the budget register, then goes to SETUP.
- SETUP: lasts exactly 1 cycle with P0_OUT=0 and C_OUT stable, so the compare logic settles. Then goes to RUN with cyc=0.
- RUN:
  - P0_OUT=1 and cyc increments each cycle. The datapath counter advances one step per RUN cycle.
  - Z_IN is sampled every RUN cycle.
  - Z_IN=1: HIT<=1, HIT_CYC<=cyc, go to DONE.
  - Z_IN=0 and cyc==budget-1 (cyc==2^CW-1 when the budget is 0): HIT<=0, HIT_CYC<=0, go to DONE.
  - Z_IN=1 on the final budget cycle counts as a hit.
- DONE:
  - P0_OUT=0.
  - HIT, HIT_CYC and C_OUT are held until ACK=1, then the block returns to IDLE.
- ABORT=1 in SETUP or RUN: go to IDLE next cycle. HIT and HIT_CYC are cleared and DONE is never asserted. ABORT is ignored in IDLE and DONE.
- START in any state other than IDLE is ignored; it is not queued.
- START and ACK in the same DONE cycle: ACK is honoured, START is dropped.
- ABORT and a Z_IN hit in the same RUN cycle: ABORT wins.
- HIT_CYC arithmetic is unsigned CW-bit. cyc never wraps, because the budget check ends RUN at 2^CW-1.

## Timing
- Reset values: state IDLE, P0_OUT=0, C_OUT=0, BUSY=0, DONE=0, HIT=0, HIT_CYC=0, internal counters 0.
- RST asserted mid-sweep: on the next edge the block returns to the reset values. P0_OUT is low from that edge.
- All outputs are registered.
- START sampled at edge t: BUSY=1 and C_OUT=MASK from t+1 (SETUP). P0_OUT=1 from t+2 (RUN cycle 0).
- Z_IN is combinational from the datapath within the same cycle. It is captured at the edge that ends the RUN cycle.
- Hit in RUN cycle k: DONE=1 and P0_OUT=0 from the following edge. At most k+1 P_0 pulses reach the datapath.
- Shortest start-to-DONE latency: 3 edges (hit in cycle 0).
- Longest start-to-DONE latency: 2+budget edges.
- ACK sampled at edge u while DONE=1: DONE=0 from u+1. A new START is accepted from u+1.

## Structure
- Package s420_ctrl_pkg holds:
  - the state enum (IDLE/SETUP/RUN/DONE);
  - CW and MW defaults;
  - the constant for the zero-budget full count.
- One sub-module, s420_cyc_cnt. It is a CW-bit counter with clear, enable and a "last" compare against the budget, used for the RUN cycle index.
- FSM, capture registers and output registers live in s420_sweep_ctrl.

## Test plan
- Reset then idle: hold RST 3 cycles, then START=0 for 5 cycles -> all outputs 0 and P0_OUT never pulses.
- Immediate hit: MASK=17'h00001, MAX_CYC=10, Z_IN forced 1 in RUN cycle 0 -> DONE at start+3, HIT=1, HIT_CYC=0, exactly one P0_OUT pulse.
- Mid hit against a real s420 instance: datapath reset to 0, MASK bit 5 set, MAX_CYC=100, Z_IN driven by the instance -> HIT=1 and HIT_CYC matches the model, P0_OUT pulse count = HIT_CYC+1.
- Timeout: MAX_CYC=4, Z_IN=0 -> exactly 4 P0_OUT pulses, DONE=1, HIT=0, HIT_CYC=0. Repeat with MAX_CYC=0 and CW=4 -> 16 pulses.
- ABORT in RUN cycle 2, coincident with Z_IN=1 -> IDLE next cycle, DONE never asserted, HIT=0.
- Handshake corners:
  - START while BUSY is ignored and MASK is unchanged.
  - In DONE with HIT=1, ACK held low 7 cycles: HIT, HIT_CYC and DONE stable for all 7 cycles.
  - START and ACK in the same DONE cycle: block returns to IDLE and no new sweep starts.
  - RST in RUN cycle 3: all outputs 0 on the next edge.
